multicycle_ctrl: RTL and testbench

- Multicycle sequencing controller for the 3-bit-opcode processor datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable and mux select each cycle.
- Stalls on a shared instruction/data memory through a ready handshake.
- Counts retired instructions and flags illegal opcodes.

---
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for the 3-bit-opcode processor datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every
// datapath enable and mux select, stalls on the shared memory via mem_ready,
// counts retired instructions and flags illegal opcodes.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             sign_or_zero,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_J     = 3'b010;
    localparam logic [2:0] OP_LW    = 3'b011;
    localparam logic [2:0] OP_SW    = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_ANDI  = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    logic [2:0]       state_r;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]       next_state_s;

    logic       pc_write_s;
    logic [1:0] pc_src_s;
    logic       ir_write_s;
    logic       i_or_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic [1:0] reg_dst_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       sign_or_zero_s;
    logic       instr_done_s;
    logic       illegal_s;

    // Control decode and next-state: everything is 0 unless the state says otherwise; reset forces all quiet.
    always_comb begin
        next_state_s   = S_FETCH;
        pc_write_s     = 1'b0;
        pc_src_s       = 2'b00;
        ir_write_s     = 1'b0;
        i_or_d_s       = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        mem_to_reg_s   = 1'b0;
        reg_write_s    = 1'b0;
        reg_dst_s      = 2'b00;
        alu_src_a_s    = 1'b0;
        alu_src_b_s    = 2'b00;
        alu_op_s       = 2'b00;
        sign_or_zero_s = 1'b0;
        instr_done_s   = 1'b0;
        illegal_s      = 1'b0;
        if (rst) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = 2'b01;
                    if (mem_ready) begin
                        ir_write_s   = 1'b1;
                        pc_write_s   = 1'b1;
                        next_state_s = S_DECODE;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // ALU precomputes the branch target while the opcode is decoded.
                    alu_src_b_s    = 2'b11;
                    sign_or_zero_s = 1'b1;
                    if (opcode == OP_ILL) begin
                        illegal_s    = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_r)
                        OP_RTYPE: begin
                            alu_src_a_s  = 1'b1;
                            alu_op_s     = 2'b10;
                            next_state_s = S_WB;
                        end
                        OP_ADDI: begin
                            alu_src_a_s    = 1'b1;
                            alu_src_b_s    = 2'b10;
                            sign_or_zero_s = 1'b1;
                            next_state_s   = S_WB;
                        end
                        OP_ANDI: begin
                            alu_src_a_s  = 1'b1;
                            alu_src_b_s  = 2'b10;
                            alu_op_s     = 2'b11;
                            next_state_s = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_src_a_s    = 1'b1;
                            alu_src_b_s    = 2'b10;
                            sign_or_zero_s = 1'b1;
                            next_state_s   = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_src_a_s  = 1'b1;
                            alu_op_s     = 2'b01;
                            pc_src_s     = 2'b01;
                            pc_write_s   = zero;
                            instr_done_s = 1'b1;
                            next_state_s = S_FETCH;
                        end
                        OP_J: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = 2'b10;
                            instr_done_s = 1'b1;
                            next_state_s = S_FETCH;
                        end
                        default: begin
                            next_state_s = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    // Request is held steady until the memory reports completion.
                    i_or_d_s = 1'b1;
                    case (op_r)
                        OP_LW: begin
                            mem_read_s = 1'b1;
                            if (mem_ready) begin
                                next_state_s = S_WB;
                            end else begin
                                next_state_s = S_MEM;
                            end
                        end
                        OP_SW: begin
                            mem_write_s = 1'b1;
                            if (mem_ready) begin
                                instr_done_s = 1'b1;
                                next_state_s = S_FETCH;
                            end else begin
                                next_state_s = S_MEM;
                            end
                        end
                        default: begin
                            next_state_s = S_FETCH;
                        end
                    endcase
                end
                S_WB: begin
                    reg_write_s  = 1'b1;
                    instr_done_s = 1'b1;
                    next_state_s = S_FETCH;
                    case (op_r)
                        OP_RTYPE: begin
                            reg_dst_s = 2'b01;
                        end
                        OP_LW: begin
                            mem_to_reg_s = 1'b1;
                        end
                        default: begin
                            reg_dst_s = 2'b00;
                        end
                    endcase
                end
                default: begin
                    // Unreachable encodings recover to FETCH with all outputs low.
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

    // State, latched opcode and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            op_r    <= 3'b000;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == S_DECODE) begin
                op_r <= opcode;
            end else begin
                op_r <= op_r;
            end
            if (instr_done_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign pc_write     = pc_write_s;
    assign pc_src       = pc_src_s;
    assign ir_write     = ir_write_s;
    assign i_or_d       = i_or_d_s;
    assign mem_read     = mem_read_s;
    assign mem_write    = mem_write_s;
    assign mem_to_reg   = mem_to_reg_s;
    assign reg_write    = reg_write_s;
    assign reg_dst      = reg_dst_s;
    assign alu_src_a    = alu_src_a_s;
    assign alu_src_b    = alu_src_b_s;
    assign alu_op       = alu_op_s;
    assign sign_or_zero = sign_or_zero_s;
    assign instr_done   = instr_done_s;
    assign illegal      = illegal_s;
    // Debug/count outputs read 0 for the whole reset window, even before the first edge.
    assign state        = rst ? 3'd0 : state_r;
    assign instr_count  = rst ? {CNT_W{1'b0}} : count_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: one record per clock cycle holding
// the inputs and the hand-derived expected outputs, plus hand-written
// sequences for opcode-change and reset-in-MEM corner cases.
module tb_multicycle_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [2:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             sign_or_zero;
    logic [2:0]       state;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    int checks;
    int failures;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .sign_or_zero (sign_or_zero),
        .state        (state),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [2:0]       op;
        logic             z;
        logic             rdy;
        logic [21:0]      exp;
        logic [CNT_W-1:0] cnt;
        string            name;
    } vec_t;

    vec_t vecs[$];

    // Expected control word, field order:
    // pc_write pc_src ir_write i_or_d mem_read mem_write mem_to_reg reg_write
    // reg_dst alu_src_a alu_src_b alu_op sign_or_zero state instr_done illegal
    function automatic logic [21:0] w(
        input logic pcw, input logic [1:0] pcs, input logic irw, input logic iod,
        input logic mr, input logic mw, input logic m2r, input logic rw,
        input logic [1:0] rd, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic soz, input logic [2:0] st,
        input logic done, input logic ill);
        w = {pcw, pcs, irw, iod, mr, mw, m2r, rw, rd, asa, asb, aop, soz, st, done, ill};
    endfunction

    task automatic add(input logic r, input logic [2:0] op, input logic z, input logic rdy,
                       input logic [21:0] exp, input logic [CNT_W-1:0] cnt, input string name);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.cnt = cnt; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, then compare before the next rising edge.
    task automatic step(input logic r, input logic [2:0] op, input logic z, input logic rdy,
                        input logic [21:0] exp, input logic [CNT_W-1:0] cnt, input string name);
        logic [21:0] act;
        @(negedge clk);
        rst = r; opcode = op; zero = z; mem_ready = rdy;
        #1;
        act = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
               reg_dst, alu_src_a, alu_src_b, alu_op, sign_or_zero, state, instr_done, illegal};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ctrl: got %b expected %b", name, act, exp);
        end
        checks++;
        if (instr_count !== cnt) begin
            failures++;
            $display("FAIL %s count: got %0d expected %0d", name, instr_count, cnt);
        end
    endtask

    initial begin
        logic [21:0] z22;
        logic [21:0] fetch_go;
        logic [21:0] fetch_wait;
        logic [21:0] decode;
        checks = 0; failures = 0;
        rst = 1'b1; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b1;

        z22        = w(0,2'b00,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'd0,0,0);
        fetch_go   = w(1,2'b00,1,0,1,0,0,0,2'b00,0,2'b01,2'b00,0,3'd0,0,0);
        fetch_wait = w(0,2'b00,0,0,1,0,0,0,2'b00,0,2'b01,2'b00,0,3'd0,0,0);
        decode     = w(0,2'b00,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,1,3'd1,0,0);

        // reset held two cycles
        add(1, 3'b000, 0, 1, z22, 16'd0, "rst0");
        add(1, 3'b000, 0, 1, z22, 16'd0, "rst1");
        // R-type
        add(0, 3'b000, 0, 1, fetch_go, 16'd0, "r_fetch");
        add(0, 3'b000, 0, 1, decode,   16'd0, "r_decode");
        add(0, 3'b000, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,3'd2,0,0), 16'd0, "r_exec");
        add(0, 3'b000, 0, 1, w(0,2'b00,0,0,0,0,0,1,2'b01,0,2'b00,2'b00,0,3'd4,1,0), 16'd0, "r_wb");
        // ADDI
        add(0, 3'b001, 0, 1, fetch_go, 16'd1, "addi_fetch");
        add(0, 3'b001, 0, 1, decode,   16'd1, "addi_decode");
        add(0, 3'b001, 1, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,3'd2,0,0), 16'd1, "addi_exec");
        add(0, 3'b001, 0, 1, w(0,2'b00,0,0,0,0,0,1,2'b00,0,2'b00,2'b00,0,3'd4,1,0), 16'd1, "addi_wb");
        // ANDI
        add(0, 3'b110, 0, 1, fetch_go, 16'd2, "andi_fetch");
        add(0, 3'b110, 0, 1, decode,   16'd2, "andi_decode");
        add(0, 3'b110, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b11,0,3'd2,0,0), 16'd2, "andi_exec");
        add(0, 3'b110, 0, 1, w(0,2'b00,0,0,0,0,0,1,2'b00,0,2'b00,2'b00,0,3'd4,1,0), 16'd2, "andi_wb");
        // LW with three wait cycles in MEM
        add(0, 3'b011, 0, 1, fetch_go, 16'd3, "lw_fetch");
        add(0, 3'b011, 0, 1, decode,   16'd3, "lw_decode");
        add(0, 3'b011, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,3'd2,0,0), 16'd3, "lw_exec");
        add(0, 3'b011, 0, 0, w(0,2'b00,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'd3,0,0), 16'd3, "lw_mem_w0");
        add(0, 3'b011, 0, 0, w(0,2'b00,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'd3,0,0), 16'd3, "lw_mem_w1");
        add(0, 3'b011, 0, 0, w(0,2'b00,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'd3,0,0), 16'd3, "lw_mem_w2");
        add(0, 3'b011, 0, 1, w(0,2'b00,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'd3,0,0), 16'd3, "lw_mem_go");
        add(0, 3'b011, 0, 1, w(0,2'b00,0,0,0,0,1,1,2'b00,0,2'b00,2'b00,0,3'd4,1,0), 16'd3, "lw_wb");
        // BEQ taken
        add(0, 3'b101, 0, 1, fetch_go, 16'd4, "beq1_fetch");
        add(0, 3'b101, 0, 1, decode,   16'd4, "beq1_decode");
        add(0, 3'b101, 1, 1, w(1,2'b01,0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,3'd2,1,0), 16'd4, "beq1_exec");
        // BEQ not taken
        add(0, 3'b101, 1, 1, fetch_go, 16'd5, "beq0_fetch");
        add(0, 3'b101, 1, 1, decode,   16'd5, "beq0_decode");
        add(0, 3'b101, 0, 1, w(0,2'b01,0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,3'd2,1,0), 16'd5, "beq0_exec");
        // J
        add(0, 3'b010, 0, 1, fetch_go, 16'd6, "j_fetch");
        add(0, 3'b010, 0, 1, decode,   16'd6, "j_decode");
        add(0, 3'b010, 1, 0, w(1,2'b10,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'd2,1,0), 16'd6, "j_exec");
        // SW zero-wait
        add(0, 3'b100, 0, 1, fetch_go, 16'd7, "sw_fetch");
        add(0, 3'b100, 0, 1, decode,   16'd7, "sw_decode");
        add(0, 3'b100, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,3'd2,0,0), 16'd7, "sw_exec");
        add(0, 3'b100, 0, 1, w(0,2'b00,0,1,0,1,0,0,2'b00,0,2'b00,2'b00,0,3'd3,1,0), 16'd7, "sw_mem");
        // illegal opcode
        add(0, 3'b111, 0, 1, fetch_go, 16'd8, "ill_fetch");
        add(0, 3'b111, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,1,3'd1,0,1), 16'd8, "ill_decode");
        add(0, 3'b000, 0, 0, fetch_wait, 16'd8, "ill_back_fetch");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp, vecs[i].cnt, vecs[i].name);
        end

        // Opcode changing after DECODE must not alter the instruction in flight.
        step(0, 3'b001, 0, 1, fetch_go, 16'd8, "chg_fetch");
        step(0, 3'b001, 0, 1, decode,   16'd8, "chg_decode");
        step(0, 3'b010, 1, 0, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,3'd2,0,0), 16'd8, "chg_exec");
        step(0, 3'b011, 0, 0, w(0,2'b00,0,0,0,0,0,1,2'b00,0,2'b00,2'b00,0,3'd4,1,0), 16'd8, "chg_wb");

        // SW abandoned by reset while waiting in MEM.
        step(0, 3'b100, 0, 1, fetch_go, 16'd9, "swr_fetch");
        step(0, 3'b100, 0, 1, decode,   16'd9, "swr_decode");
        step(0, 3'b100, 0, 1, w(0,2'b00,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,3'd2,0,0), 16'd9, "swr_exec");
        step(0, 3'b100, 0, 0, w(0,2'b00,0,1,0,1,0,0,2'b00,0,2'b00,2'b00,0,3'd3,0,0), 16'd9, "swr_mem_wait");
        step(1, 3'b100, 0, 0, z22, 16'd0, "swr_rst");
        step(0, 3'b100, 0, 1, fetch_go, 16'd0, "swr_after");
        step(0, 3'b100, 0, 1, decode,   16'd0, "swr_after_decode");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
